// File: rtl/audio_stream_pkg.sv
// Shared types and default sizes for the audio sample stream reader.
package audio_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      ABORT = 2'd3
   } state_t;

   localparam int WORD_BYTES        = 4;
   localparam int SAMPLE_W          = 32;
   localparam int DEF_AVM_ADDR_W    = 18;
   localparam int DEF_LEN_W         = 17;
   localparam int DEF_FIFO_DEPTH    = 16;
   localparam int DEF_MAX_PENDING   = 4;

endpackage

// File: rtl/audio_sample_fifo.sv
// First-word-fall-through sample FIFO: the head word is always on rd_data,
// and a word pushed on one edge is visible (empty low) right after that edge.
module audio_sample_fifo
   import audio_stream_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int DATA_W     = SAMPLE_W
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   input  logic [DATA_W-1:0]             wr_data,
   output logic [DATA_W-1:0]             rd_data,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          empty,
   output logic                          full
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & ~flush & (~full | do_pop);
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage array, cleared on reset so the head word reads as zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/audio_stream_reader.sv
// Avalon-MM pipelined read master that streams sample words from the sample
// memory into an Avalon-ST source. Reads are only issued when the FIFO has
// room for every outstanding response, so returned data is never dropped.
module audio_stream_reader
   import audio_stream_pkg::*;
#(
   parameter int AVM_ADDR_W  = DEF_AVM_ADDR_W,
   parameter int LEN_W       = DEF_LEN_W,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int MAX_PENDING = DEF_MAX_PENDING
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [AVM_ADDR_W-1:0]   base_addr,
   input  logic [LEN_W-1:0]        length,
   input  logic                    loop_en,
   output logic                    busy,
   output logic                    done,
   output logic [AVM_ADDR_W-1:0]   avm_address,
   output logic                    avm_read,
   input  logic                    avm_waitrequest,
   input  logic [SAMPLE_W-1:0]     avm_readdata,
   input  logic                    avm_readdatavalid,
   output logic [SAMPLE_W-1:0]     st_data,
   output logic                    st_valid,
   input  logic                    st_ready
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int PEND_W = $clog2(MAX_PENDING + 1);
   localparam int SUM_W  = ((CNT_W > PEND_W) ? CNT_W : PEND_W) + 1;

   state_t                  state;
   logic [AVM_ADDR_W-1:0]   addr;
   logic [AVM_ADDR_W-1:0]   base_reg;
   logic [AVM_ADDR_W-1:0]   base_aligned;
   logic [LEN_W-1:0]        remaining;
   logic [LEN_W-1:0]        len_reg;
   logic                    loop_reg;
   logic [PEND_W-1:0]       pending;
   logic [PEND_W-1:0]       pending_next;
   logic [CNT_W-1:0]        fifo_count;
   logic [CNT_W-1:0]        count_next;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    accept;
   logic                    stalled;
   logic                    ret;
   logic                    abort_now;
   logic                    push;
   logic                    pop;
   logic                    credit_next;

   assign base_aligned = base_addr & ~AVM_ADDR_W'(WORD_BYTES - 1);
   assign avm_address  = addr;
   assign st_valid     = ~fifo_empty;

   // Per-cycle handshakes and the pending/occupancy values after this edge;
   // the read request for the next cycle is decided from those values.
   always_comb begin
      accept       = avm_read & ~avm_waitrequest;
      stalled      = avm_read & avm_waitrequest;
      ret          = avm_readdatavalid & (pending != '0);
      abort_now    = abort & (state != IDLE);
      push         = ret & ~abort_now & ((state == FETCH) | (state == DRAIN)) & (~fifo_full | pop);
      pop          = st_valid & st_ready;
      pending_next = pending + PEND_W'(accept) - PEND_W'(ret);
      if (abort_now) count_next = '0;
      else           count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
      credit_next  = (pending_next < PEND_W'(MAX_PENDING)) &&
                     ((SUM_W'(count_next) + SUM_W'(pending_next)) < SUM_W'(FIFO_DEPTH));
   end

   // Control FSM: request issue, pass/loop sequencing, drain and abort.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         addr      <= '0;
         base_reg  <= '0;
         remaining <= '0;
         len_reg   <= '0;
         loop_reg  <= 1'b0;
         pending   <= '0;
         avm_read  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done    <= 1'b0;
         pending <= pending_next;
         case (state)
            IDLE: begin
               avm_read <= 1'b0;
               busy     <= 1'b0;
               if (start) begin
                  if (length != '0) begin
                     state     <= FETCH;
                     busy      <= 1'b1;
                     base_reg  <= base_aligned;
                     addr      <= base_aligned;
                     len_reg   <= length;
                     remaining <= length;
                     loop_reg  <= loop_en;
                     avm_read  <= credit_next;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (abort_now) begin
                  state    <= ABORT;
                  avm_read <= stalled;
               end else if (stalled) begin
                  avm_read <= 1'b1;
               end else if (accept) begin
                  if (remaining == LEN_W'(1)) begin
                     if (loop_reg) begin
                        addr      <= base_reg;
                        remaining <= len_reg;
                        avm_read  <= credit_next;
                     end else begin
                        addr      <= addr + AVM_ADDR_W'(WORD_BYTES);
                        remaining <= '0;
                        state     <= DRAIN;
                        avm_read  <= 1'b0;
                     end
                  end else begin
                     addr      <= addr + AVM_ADDR_W'(WORD_BYTES);
                     remaining <= remaining - LEN_W'(1);
                     avm_read  <= credit_next;
                  end
               end else begin
                  avm_read <= credit_next;
               end
            end
            DRAIN: begin
               avm_read <= 1'b0;
               if (abort_now) begin
                  state <= ABORT;
               end else if (pending_next == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ABORT: begin
               avm_read <= stalled;
               if ((pending_next == '0) && !stalled) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               avm_read <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   audio_sample_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DATA_W     (SAMPLE_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (abort_now),
      .wr_data (avm_readdata),
      .rd_data (st_data),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

endmodule

// File: doc/audio_stream_reader.md
Name: audio_stream_reader

Overview:
- Avalon-MM pipelined read master that fetches 32-bit audio sample words from the on-chip sample memory (single-port, 65536 x 32).
- Presents the fetched words as an Avalon-ST source toward the audio codec serializer.
- Sits between the memory's slave port (through the interconnect) and the codec TX path; started by the Nios control registers.

Parameters:
- AVM_ADDR_W, 18, byte-address width on the master port (65536 words x 4 bytes).
- LEN_W, 17, width of the transfer length in words (max 65536).
- FIFO_DEPTH, 16, sample FIFO depth in words; power of 2, >= 4.
- MAX_PENDING, 4, maximum outstanding reads not yet returned.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches base_addr, length, loop_en.
- abort  in  1  one-cycle pulse; cancels the current transfer.
- base_addr  in  AVM_ADDR_W  first byte address; bits [1:0] ignored (forced 0).
- length  in  LEN_W  number of words per pass.
- loop_en  in  1  1 = restart at base_addr after the last word, until abort.
- busy  out  1  high from the start cycle until IDLE is re-entered.
- done  out  1  one-cycle pulse when the final word of a non-loop transfer has returned.
- avm_address  out  AVM_ADDR_W  read byte address.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  stall; the request is held unchanged while high.
- avm_readdata  in  32  returned word.
- avm_readdatavalid  in  1  readdata qualifier.
- st_data  out  32  sample word, memory order.
- st_valid  out  1  st_data valid.
- st_ready  in  1  sink accepts when st_valid & st_ready.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, pending = 0.
- State IDLE:
  - start with length != 0: latch inputs, addr = base_addr, remaining = length, go to FETCH.
  - start with length == 0: pulse done on the next cycle, no reads issued, stay IDLE.
- State FETCH:
  - avm_read is asserted when pending < MAX_PENDING and fifo_count + pending < FIFO_DEPTH. This credit rule means the FIFO never overflows.
  - A request is accepted on the cycle with avm_read & ~avm_waitrequest. On acceptance: addr += 4, remaining -= 1, pending += 1.
  - avm_address/avm_read must not change while waitrequest is high.
  - Last request accepted: loop_en = 1 → addr = base_addr, remaining = length, stay in FETCH. loop_en = 0 → go to DRAIN.
- State DRAIN: no requests. When pending reaches 0, pulse done, then IDLE.
- Every readdatavalid: write avm_readdata into the FIFO and decrement pending. An accept and a return in the same cycle leave pending unchanged.
- Address arithmetic is modulo 2^AVM_ADDR_W; addr wraps past 0x3FFFC to 0 silently.
- Latency:
  - First avm_read is asserted the cycle after start.
  - A word written to the FIFO appears on st_data/st_valid the next cycle (registered FIFO output, first-word-fall-through).
- FIFO:
  - st_valid = ~empty.
  - A simultaneous push and pop keeps the count constant.
  - FIFO contents persist after done; busy does not wait for the FIFO to drain.
- Abort (any state except IDLE) → state ABORT:
  - avm_read deasserts the next cycle, unless a request is currently stalled. A stalled request is held until accepted and counted as pending.
  - Returning data is discarded.
  - FIFO is flushed on entry to ABORT and stays empty.
  - When pending reaches 0, go to IDLE with no done pulse.
- start while busy is ignored. Abort in IDLE is ignored. Abort and start in the same cycle while busy: abort wins.
- Asynchronous reset mid-transfer: everything returns to reset values immediately. Outstanding slave responses that arrive after release of reset are ignored, because pending = 0 and the state is IDLE.

Decomposition:
- Package audio_stream_pkg: state enum (IDLE, FETCH, DRAIN, ABORT), WORD_BYTES = 4, default widths.
- Sub-module audio_sample_fifo: synchronous FWFT FIFO with push, pop, flush, count, empty and full; parameter FIFO_DEPTH.

Test Plan:
- base 0x0100, length 8, loop 0, slave latency 1, st_ready = 1 → addresses 0x100..0x11C in order, 8 words out in memory order, one done pulse, busy low afterwards.
- Same transfer with waitrequest high for 3 cycles on the 2nd request → address 0x104 held stable, no word duplicated or lost.
- length 40, st_ready = 0 → exactly 16 words fetched, fifo_count + pending never exceeds 16, pending never exceeds 4. Then st_ready = 1 → all 40 words arrive in order.
- base 0x3FFF8, length 4 → addresses 0x3FFF8, 0x3FFFC, 0x00000, 0x00004.
- loop_en = 1, length 3, base 0x40 → output pattern 0x40, 0x44, 0x48 repeating. abort with 2 reads pending → both returns discarded, FIFO empty, no done pulse, IDLE after the last return.
- length 0 → done pulse the cycle after start, avm_read never asserted. reset_n low mid-FETCH → all outputs 0 immediately.
